// File: rtl/crc_pkg.sv
// crc_pkg: shared definitions for the parametrised CRC engine and its
// receive-side users.
//   state_t      engine FSM states (IDLE/SHIFT/DONE)
//   CRC16_8005   CRC-16 (IBM/UMTS) polynomial, x^16 term implicit
//   CRC16_1021   CRC-16 CCITT polynomial, x^16 term implicit
//   CRC8_07      CRC-8 ATM polynomial, x^8 term implicit
//   clog2()      ceiling log2, usable in parameter expressions
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [15:0] CRC16_8005 = 16'h8005;
  localparam logic [15:0] CRC16_1021 = 16'h1021;
  localparam logic [7:0]  CRC8_07    = 8'h07;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_step.sv
// crc_step: combinational CRC advance over BITS_PER_CLK input bits.
// bits[BITS_PER_CLK-1] is consumed first (MSB-first order).
// Ports:
//   crc_in    in   CRC_W         current register value
//   bits      in   BITS_PER_CLK  input bits for this step
//   crc_next  out  CRC_W         register value after all bits
module crc_step
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W        = 16,
  parameter logic [CRC_W-1:0] POLY         = CRC16_8005,
  parameter int unsigned      BITS_PER_CLK = 1
) (
  input  logic [CRC_W-1:0]        crc_in,
  input  logic [BITS_PER_CLK-1:0] bits,
  output logic [CRC_W-1:0]        crc_next
);

  logic [CRC_W-1:0]        acc;
  logic [BITS_PER_CLK-1:0] pending;
  logic                    fb;

  always_comb begin
    acc     = crc_in;
    pending = bits;
    fb      = 1'b0;
    for (int unsigned i = 0; i < BITS_PER_CLK; i++) begin
      fb      = acc[CRC_W-1] ^ pending[BITS_PER_CLK-1];
      acc     = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      pending = pending << 1;
    end
    crc_next = acc;
  end

endmodule

// File: rtl/crc_engine_param.sv
// crc_engine_param: parametrised CRC generator/checker over a parallel frame.
// A start in IDLE latches data/mode/check_crc, then SHIFT consumes
// BITS_PER_CLK bits per cycle MSB-first for FRAME_W/BITS_PER_CLK cycles,
// then one DONE cycle registers the result and pulses done.
// Optional build macro CRC_FINAL_XOR_EN: result = register ^ XOROUT
// (both for crc_out and for the check); otherwise XOROUT is ignored.
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   start      in   1        request, sampled only in IDLE
//   mode       in   1        0 = generate, 1 = check
//   data       in   FRAME_W  frame, bit FRAME_W-1 first
//   check_crc  in   CRC_W    received CRC (check mode)
//   busy       out  1        engine not idle
//   done       out  1        one-cycle result-valid pulse
//   crc_out    out  CRC_W    computed CRC, held until next done
//   crc_err    out  1        check mismatch, held until next done
module crc_engine_param
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W        = 16,
  parameter logic [CRC_W-1:0] POLY         = CRC16_8005,
  parameter logic [CRC_W-1:0] INIT         = '0,
  parameter int unsigned      FRAME_W      = 66,
  parameter int unsigned      BITS_PER_CLK = 1,
  parameter logic [CRC_W-1:0] XOROUT       = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [FRAME_W-1:0] data,
  input  logic [CRC_W-1:0]   check_crc,
  output logic               busy,
  output logic               done,
  output logic [CRC_W-1:0]   crc_out,
  output logic               crc_err
);

  localparam int unsigned      N     = FRAME_W / BITS_PER_CLK;
  localparam int unsigned      CNT_W = clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

`ifdef CRC_FINAL_XOR_EN
  localparam logic [CRC_W-1:0] FINAL_MASK = XOROUT;
`else
  localparam logic [CRC_W-1:0] FINAL_MASK = XOROUT & '0;
`endif

  if (FRAME_W % BITS_PER_CLK != 0) begin : g_bad_split
    $error("crc_engine_param: FRAME_W must be a multiple of BITS_PER_CLK");
  end
  if (CRC_W < 4 || CRC_W > 32) begin : g_bad_width
    $error("crc_engine_param: CRC_W must be within 4..32");
  end

  state_t             state;
  state_t             state_next;
  logic [FRAME_W-1:0] frame;
  logic               mode_q;
  logic [CRC_W-1:0]   chk_q;
  logic [CRC_W-1:0]   crc_q;
  logic [CRC_W-1:0]   crc_adv;
  logic [CRC_W-1:0]   result;
  logic [CNT_W-1:0]   cnt;

  crc_step #(
    .CRC_W       (CRC_W),
    .POLY        (POLY),
    .BITS_PER_CLK(BITS_PER_CLK)
  ) u_step (
    .crc_in  (crc_q),
    .bits    (frame[FRAME_W-1 -: BITS_PER_CLK]),
    .crc_next(crc_adv)
  );

  assign result = crc_q ^ FINAL_MASK;
  assign busy   = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The result is registered on the edge that leaves DONE, so done and
  // the new crc_out/crc_err become visible together in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame   <= '0;
      mode_q  <= 1'b0;
      chk_q   <= '0;
      crc_q   <= INIT;
      cnt     <= '0;
      done    <= 1'b0;
      crc_out <= '0;
      crc_err <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            frame  <= data;
            mode_q <= mode;
            chk_q  <= check_crc;
            crc_q  <= INIT;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          crc_q <= crc_adv;
          frame <= frame << BITS_PER_CLK;
          cnt   <= cnt + CNT_W'(1);
        end
        DONE: begin
          crc_out <= result;
          crc_err <= mode_q & (result != chk_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/crc_engine_param.md
Name: crc_engine_param

Overview:
- Parametrised successor to the team's fixed 66-bit, bit-serial CRC-16 generator.
- Computes a CRC of configurable width, polynomial and init value over a configurable-length parallel frame, processing BITS_PER_CLK bits per clock.
- Adds a start/busy/done handshake and a check mode that compares against a received CRC and flags mismatches.
- Sits between the frame assembler and the serial sender on transmit, and after the deframer on receive.

Parameters:
- CRC_W, 16: CRC register width (4..32).
- POLY, 16'h8005: generator polynomial, implicit x^CRC_W term omitted.
- INIT, 16'h0000: register value loaded at start.
- FRAME_W, 66: frame length in bits.
- BITS_PER_CLK, 1: bits consumed per SHIFT cycle; FRAME_W % BITS_PER_CLK must be 0, otherwise elaboration error.
- XOROUT, 16'h0000: final XOR mask; used only with CRC_FINAL_XOR_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = generate, 1 = check; latched on accepted start.
- data  in  FRAME_W  frame; bit FRAME_W-1 processed first (MSB-first); latched on accepted start.
- check_crc  in  CRC_W  received CRC; latched on accepted start; ignored when mode=0.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, result valid.
- crc_out  out  CRC_W  computed CRC; holds until next done.
- crc_err  out  1  check result; holds until next done.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; crc register=INIT; bit counter=0; busy=0, done=0, crc_out=0, crc_err=0.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at a clock edge latches data, mode and check_crc, loads register=INIT, clears counter, goes to SHIFT. start=0 stays in IDLE.
- SHIFT: each cycle consumes BITS_PER_CLK bits, MSB-first. Per bit: s = reg[CRC_W-1] ^ bit; reg = (reg<<1) ^ (s ? POLY : 0). Counter advances by 1 per cycle. After N = FRAME_W/BITS_PER_CLK cycles, go to DONE.
- DONE (exactly one cycle), outputs registered:
  - done=1.
  - crc_out = final register value.
  - crc_err = mode & (final value != check_crc); crc_err=0 in generate mode.
  - Next state is IDLE.
- Latency: start sampled at edge 0; done is high in the cycle after edge N+1. Back-to-back throughput is one frame per N+2 cycles.
- start while busy (SHIFT or DONE): ignored, not queued. Input changes after acceptance have no effect.
- done is never high for two consecutive cycles.
- crc_out and crc_err change only in the DONE cycle, or on reset.
- Reset mid-SHIFT: frame aborted, no done pulse, outputs cleared.
- Counter width: clog2(N+1); no wrap-around within a frame.

Optional Feature:
- Macro CRC_FINAL_XOR_EN.
- Defined: crc_out = register ^ XOROUT, and the check compares the XORed value against check_crc.
- Undefined: XOROUT is ignored and crc_out is the raw register value.
- Latency is the same in both cases.

Decomposition:
- Package crc_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - named polynomial constants CRC16_8005, CRC16_1021, CRC8_07;
  - a clog2 helper function.
- Sub-module crc_step: combinational next-register function for BITS_PER_CLK bits, parameterised by CRC_W, POLY and BITS_PER_CLK. It is instantiated once in the engine and is reusable by the receiver.

Test Plan:
1. Defaults, data = 66'h0, mode=0 -> after 67 cycles done pulses once, crc_out=16'h0000, crc_err=0, busy high for 67 cycles.
2. Defaults, data = 66'h1 (single 1 in the last bit) -> crc_out=16'h8005.
3. FRAME_W=72, BITS_PER_CLK=8, data = ASCII "123456789" -> done 10 cycles after start, crc_out=16'hFEE8. With CRC_FINAL_XOR_EN and XOROUT=16'hFFFF -> crc_out=16'h0117.
4. Check mode, same frame as test 3:
   - check_crc=16'hFEE8 -> crc_err=0.
   - check_crc=16'hFEE9 -> crc_err=1.
   - Generate mode with check_crc=16'hFEE9 -> crc_err=0.
5. start held high continuously and data changed mid-frame -> result matches the data latched at acceptance; done pulses are spaced exactly N+2 cycles apart.
6. rst asserted asynchronously mid-SHIFT, between clock edges -> all outputs 0 immediately, no done pulse; a new start afterwards yields the correct CRC.
